// File: rtl/base_address_wr.sv
// Mapping Table Header producer: clears the ready flag, writes NUM_CH channel
// base addresses into the header BRAM, then publishes the flag.
module base_address_wr #(
    parameter logic [31:0] START_ADDR   = 32'h4580_0000,
    parameter logic [31:0] OFFSET_CONST = 32'h0000_0004,
    parameter logic [31:0] FLAG_ADDR    = 32'h4580_0020,
    parameter int          NUM_CH       = 8,
    parameter logic [31:0] FLAG_VALUE   = 32'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        ent_valid,
    input  logic [31:0] ent_data,
    output logic        ent_ready,
    output logic        busy,
    output logic        done,
    output logic        ram_clk,
    output logic        ram_rst,
    output logic [31:0] ram_addr,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_wd_data
);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, FLAG, DONE} state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_CH - 1);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic        en_q, en_d;
    logic [3:0]  we_q, we_d;
    logic        done_q, done_d;
    logic [31:0] ent_addr;

    assign ent_addr = START_ADDR + 32'(idx_q) * OFFSET_CONST;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        en_d    = 1'b0;
        we_d    = 4'h0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // The flag-clear write is issued on the transition itself, so
                // the table is invalidated before the first entry can land.
                if (start && !abort) begin
                    en_d    = 1'b1;
                    we_d    = 4'hF;
                    addr_d  = FLAG_ADDR;
                    wd_d    = 32'd0;
                    idx_d   = 3'd0;
                    state_d = LOAD;
                end
            end
            CLR: state_d = LOAD;
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (ent_valid) begin
                    en_d   = 1'b1;
                    we_d   = 4'hF;
                    addr_d = ent_addr;
                    wd_d   = ent_data;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) state_d = FLAG;
                end
            end
            FLAG: begin
                en_d    = 1'b1;
                we_d    = 4'hF;
                addr_d  = FLAG_ADDR;
                wd_d    = FLAG_VALUE;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            addr_q  <= FLAG_ADDR;
            wd_q    <= 32'd0;
            en_q    <= 1'b0;
            we_q    <= 4'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            en_q    <= en_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    assign ent_ready   = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign ram_clk     = clk;
    assign ram_rst     = 1'b0;
    assign ram_addr    = addr_q;
    assign ram_en      = en_q;
    assign ram_we      = we_q;
    assign ram_wd_data = wd_q;

endmodule

// File: tb/tb_base_address_wr.sv
// Bench for base_address_wr: timeline model of expected bus activity, BRAM
// image built from observed writes, plus literal checks on a NUM_CH=1 copy.
module tb_base_address_wr;

    localparam logic [31:0] START = 32'h4580_0000;
    localparam logic [31:0] FLAG  = 32'h4580_0020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, ent_valid = 1'b0;
    logic [31:0] ent_data = 32'd0;
    logic        ent_ready, busy, done, ram_clk, ram_rst, ram_en;
    logic [31:0] ram_addr, ram_wd_data;
    logic [3:0]  ram_we;

    logic        s1_start = 1'b0, s1_abort = 1'b0, s1_valid = 1'b0;
    logic [31:0] s1_data = 32'd0;
    logic        s1_ready, s1_busy, s1_done, s1_rclk, s1_rrst, s1_en;
    logic [31:0] s1_addr, s1_wd;
    logic [3:0]  s1_we;

    always #5 clk = ~clk;

    base_address_wr dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .ent_valid(ent_valid), .ent_data(ent_data), .ent_ready(ent_ready),
        .busy(busy), .done(done), .ram_clk(ram_clk), .ram_rst(ram_rst),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
        .ram_wd_data(ram_wd_data)
    );

    base_address_wr #(.NUM_CH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(s1_abort),
        .ent_valid(s1_valid), .ent_data(s1_data), .ent_ready(s1_ready),
        .busy(s1_busy), .done(s1_done), .ram_clk(s1_rclk), .ram_rst(s1_rrst),
        .ram_addr(s1_addr), .ram_en(s1_en), .ram_we(s1_we),
        .ram_wd_data(s1_wd)
    );

    // Model: every accepted event schedules its bus write / done pulse at the
    // absolute cycle the latency rules put it in.
    int          cyc = 0;
    int          mode = 0;          // 0 idle, 1 loading, 2 publishing
    int          n_ent = 0;
    int          pub_end = 0;
    bit          exp_wr[int];
    logic [31:0] exp_a[int];
    logic [31:0] exp_d[int];
    bit          exp_done[int];
    bit          e_rdy[int];
    bit          e_busy[int];

    always @(posedge clk) begin
        int c;
        c = cyc;
        if (!rst_n) begin
            mode = 0;
            n_ent = 0;
            exp_wr.delete();
            exp_done.delete();
        end else begin
            case (mode)
                0: if (start && !abort) begin
                    exp_wr[c+1] = 1'b1; exp_a[c+1] = FLAG; exp_d[c+1] = 32'd0;
                    mode = 1;
                    n_ent = 0;
                end
                1: if (abort) begin
                    mode = 0;
                end else if (ent_valid) begin
                    exp_wr[c+1] = 1'b1;
                    exp_a[c+1] = START + 32'(4 * n_ent);
                    exp_d[c+1] = ent_data;
                    n_ent++;
                    if (n_ent == 8) begin
                        exp_wr[c+2] = 1'b1; exp_a[c+2] = FLAG; exp_d[c+2] = 32'd1;
                        exp_done[c+3] = 1'b1;
                        pub_end = c + 3;
                        mode = 2;
                    end
                end
                default: if (c + 1 >= pub_end) mode = 0;
            endcase
        end
        e_rdy[c+1]  = (mode == 1);
        e_busy[c+1] = (mode != 0);
        cyc = c + 1;
    end

    int          n_chk = 0, n_err = 0;
    int          wr_cnt = 0, clr_cnt = 0, flag1_cnt = 0, done_cnt = 0, done_cyc = -1;
    logic [31:0] mem[logic [31:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
    endfunction

    task automatic cmp_loop();
        logic [31:0] held_a, held_d;
        bit          ew;
        held_a = FLAG;
        held_d = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_a = FLAG;
                held_d = 32'd0;
                chk("rst_en", 32'(ram_en), 32'd0);
                chk("rst_we", 32'(ram_we), 32'd0);
                chk("rst_addr", ram_addr, FLAG);
                chk("rst_data", ram_wd_data, 32'd0);
                chk("rst_flags", {29'd0, ent_ready, busy, done}, 32'd0);
            end else begin
                ew = exp_wr.exists(cyc);
                if (ew) begin
                    held_a = exp_a[cyc];
                    held_d = exp_d[cyc];
                end
                chk("ram_en", 32'(ram_en), 32'(ew));
                chk("ram_we", 32'(ram_we), ew ? 32'hF : 32'h0);
                chk("ram_addr", ram_addr, held_a);
                chk("ram_wd_data", ram_wd_data, held_d);
                chk("ent_ready", 32'(ent_ready), 32'(e_rdy[cyc]));
                chk("busy", 32'(busy), 32'(e_busy[cyc]));
                chk("done", 32'(done), 32'(exp_done.exists(cyc)));
                chk("ties", {30'd0, ram_rst, ram_clk}, 32'd0);
                if (ram_en && ram_we == 4'hF) begin
                    mem[ram_addr] = ram_wd_data;
                    wr_cnt++;
                    if (ram_addr == FLAG && ram_wd_data == 32'd0) clr_cnt++;
                    if (ram_addr == FLAG && ram_wd_data == 32'd1) flag1_cnt++;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    endtask

    task automatic tick(input int k = 1);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int w0, c0, f0, d0, hs;

    initial begin
        fork
            cmp_loop();
        join_none

        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Normal back-to-back update
        w0 = wr_cnt; f0 = flag1_cnt;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            ent_valid = 1'b1; ent_data = 32'h1000_0000 + 32'(i);
            hs = cyc;
            tick();
        end
        ent_valid = 1'b0;
        tick(6);
        chk("norm_writes", 32'(wr_cnt - w0), 32'd10);
        chk("norm_flag1", 32'(flag1_cnt - f0), 32'd1);
        chk("norm_done_lat", 32'(done_cyc), 32'(hs + 3));
        chk("norm_e0", rd(32'h4580_0000), 32'h1000_0000);
        chk("norm_e7", rd(32'h4580_001C), 32'h1000_0007);
        chk("norm_flag", rd(FLAG), 32'd1);

        // Gapped stream; junk valid alongside start must be ignored
        w0 = wr_cnt;
        ent_valid = 1'b1; ent_data = 32'hBAD0_BAD0;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            ent_valid = 1'b1; ent_data = 32'h2000_0000 + 32'(i);
            tick();
            ent_valid = 1'b0; ent_data = 32'hBAD0_BAD0;
            tick();
        end
        tick(5);
        chk("gap_writes", 32'(wr_cnt - w0), 32'd10);
        chk("gap_e3", rd(32'h4580_000C), 32'h2000_0003);
        chk("gap_e7", rd(32'h4580_001C), 32'h2000_0007);
        chk("gap_flag", rd(FLAG), 32'd1);

        // Abort after 3 entries; entry in the abort cycle is dropped
        f0 = flag1_cnt; d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            ent_valid = 1'b1; ent_data = 32'h3000_0000 + 32'(i);
            tick();
        end
        abort = 1'b1; ent_data = 32'h3000_0003;
        tick();
        abort = 1'b0; ent_valid = 1'b0;
        tick(6);
        chk("abort_flag", rd(FLAG), 32'd0);
        chk("abort_e2", rd(32'h4580_0008), 32'h3000_0002);
        chk("abort_e3", rd(32'h4580_000C), 32'h2000_0003);
        chk("abort_flag1", 32'(flag1_cnt - f0), 32'd0);
        chk("abort_done", 32'(done_cnt - d0), 32'd0);

        // start mid-LOAD ignored, then start+abort in IDLE
        c0 = clr_cnt;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            ent_valid = 1'b1; ent_data = 32'h6000_0000 + 32'(i);
            start = (i == 2);
            tick();
        end
        start = 1'b0; ent_valid = 1'b0;
        tick(5);
        chk("restart_clr", 32'(clr_cnt - c0), 32'd1);
        chk("restart_e7", rd(32'h4580_001C), 32'h6000_0007);
        w0 = wr_cnt;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick(4);
        chk("sa_writes", 32'(wr_cnt - w0), 32'd0);

        // Reset in LOAD after 5 entries, then a full run
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            ent_valid = 1'b1; ent_data = 32'h4000_0000 + 32'(i);
            tick();
        end
        ent_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(ent_ready), 32'd0);
        chk("arst_en", 32'(ram_en), 32'd0);
        chk("arst_addr", ram_addr, FLAG);
        chk("arst_flag", rd(FLAG), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            ent_valid = 1'b1; ent_data = 32'h5000_0000 + 32'(i);
            tick();
        end
        ent_valid = 1'b0;
        tick(6);
        chk("rerun_e5", rd(32'h4580_0014), 32'h5000_0005);
        chk("rerun_flag", rd(FLAG), 32'd1);

        // NUM_CH=1 instance, hand-computed cycle by cycle
        s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        chk("n1_clr", {s1_en, s1_we, 3'd0, s1_ready, s1_busy}, {1'b1, 4'hF, 3'd0, 1'b1, 1'b1});
        chk("n1_clr_a", s1_addr, FLAG);
        chk("n1_clr_d", s1_wd, 32'd0);
        s1_valid = 1'b1; s1_data = 32'hABCD_0000;
        tick();
        s1_valid = 1'b0;
        chk("n1_ent", {s1_en, s1_we, 3'd0, s1_ready, s1_busy}, {1'b1, 4'hF, 3'd0, 1'b0, 1'b1});
        chk("n1_ent_a", s1_addr, 32'h4580_0000);
        chk("n1_ent_d", s1_wd, 32'hABCD_0000);
        tick();
        chk("n1_flag_a", s1_addr, FLAG);
        chk("n1_flag_d", s1_wd, 32'd1);
        chk("n1_flag_en", 32'(s1_en), 32'd1);
        tick();
        chk("n1_done", {29'd0, s1_done, s1_busy, s1_en}, 32'b100);
        tick();
        chk("n1_done_end", 32'(s1_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/base_address_wr.md
Name: base_address_wr

Overview:
- Producer side of the Mapping Table Header handshake: writes NUM_CH channel base addresses into the header BRAM, then publishes the ready flag (value 1 at FLAG_ADDR).
- Downstream channel logic polls FLAG_ADDR and starts transfers only after that flag write.
- Sits between the host-side loader (entry stream) and the BRAM port-B interface.
- Invalidates the flag before any entry is rewritten, so a reader never sees a half-updated table.

Parameters:
- START_ADDR, 32'h4580_0000: BRAM address of entry 0 (channel 0 base address).
- OFFSET_CONST, 32'h0000_0004: address stride between entries.
- FLAG_ADDR, 32'h4580_0020: address of the ready flag word.
- NUM_CH, 8: entries per header, range 1..8; the index counter is 3 bits.
- FLAG_VALUE, 32'd1: value written to publish the header.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a header update.
- abort  in  1  synchronous cancel of an in-progress update.
- ent_valid  in  1  entry stream valid.
- ent_data  in  32  channel base address, delivered in channel order 0..NUM_CH-1.
- ent_ready  out  1  entry stream ready.
- busy  out  1  update in progress.
- done  out  1  one-cycle pulse after the flag write.
- ram_clk  out  1  tied to clk.
- ram_rst  out  1  tied to 0.
- ram_addr  out  32  BRAM address.
- ram_en  out  1  BRAM enable.
- ram_we  out  4  byte write enables.
- ram_wd_data  out  32  BRAM write data.

Behaviour:
Reset and bus rules
- Reset (async, rst_n=0): state=IDLE, idx=0, ram_addr=FLAG_ADDR, ram_en=0, ram_we=4'h0, ram_wd_data=0, ent_ready=0, busy=0, done=0.
- ram_addr, ram_en, ram_we and ram_wd_data are registered. A bus write occurs in any cycle with ram_en=1 and ram_we=4'hF. Every write is a full word.
- The bus is idle (ram_en=0, ram_we=0) in every cycle not listed below. Address and data hold their last values when idle.

State machine: IDLE, CLR, LOAD, FLAG, DONE.
- IDLE:
  - start=1 and abort=0 at cycle t -> in cycle t+1: flag-clear write on bus (addr=FLAG_ADDR, data=0), state=LOAD, idx=0, busy=1.
- LOAD:
  - ent_ready=1, asserted combinationally from state==LOAD.
  - A handshake (ent_valid and ent_ready) at cycle k -> in cycle k+1 the bus writes addr = START_ADDR + idx*OFFSET_CONST, data = ent_data captured at k. idx then increments.
  - Throughput is one entry per cycle. Cycles with no handshake produce no write.
  - A handshake with idx==NUM_CH-1 -> next state=FLAG. The last entry write appears in the first FLAG cycle.
- FLAG:
  - Lasts one cycle. ent_ready=0.
  - Registers the flag write, so the bus shows addr=FLAG_ADDR, data=FLAG_VALUE in the following cycle. State=DONE in that cycle.
- DONE:
  - Lasts one cycle. The flag write is on the bus.
  - In the next cycle: done=1 for one cycle, busy=0, state=IDLE, bus idle.
- Latency: from the last entry handshake at k, the entry write is at k+1, the flag write at k+2, and done=1 at k+3.

Boundary conditions
- start while busy: ignored. No restart, no extra flag clear.
- start and abort in the same cycle in IDLE: abort wins; stay IDLE.
- abort in LOAD: next cycle state=IDLE, busy=0, ent_ready=0, no done. Any entry write already registered from a handshake in the abort cycle is suppressed. The flag in memory remains 0.
- abort in FLAG or DONE: ignored. Publication completes.
- ent_valid while not in LOAD: no handshake; data is ignored.
- Reset mid-update: immediate return to reset values. The flag in memory stays 0 because CLR precedes any entry write.
- Address arithmetic is unsigned 32-bit. No wrap is expected for legal parameters.
- A new start after done begins a fresh update with idx=0.

Test Plan:
- Normal update: reset; start; stream 0x1000_0000+i for i=0..7 back-to-back -> bus writes 0 to 0x4580_0020, then 0x1000_000i to 0x4580_0000+4i (one per cycle), then 1 to 0x4580_0020; done=1 exactly 3 cycles after the 8th handshake; busy high from start+1 through the flag-write cycle.
- Gapped stream: ent_valid toggled every other cycle -> writes only in cycles after handshakes; addresses contiguous 0x4580_0000..0x4580_001C; single flag write of 1.
- Abort after 3 entries -> no further writes, no flag=1 write, busy=0 next cycle, done never asserts; BRAM model shows flag=0.
- start pulsed again mid-LOAD, and start+abort together in IDLE -> no extra flag clear, no restart; second case stays IDLE with the bus idle.
- Reset asserted in LOAD after 5 entries, then released and a full update run -> outputs return to reset values asynchronously; second run produces the full normal sequence; final BRAM flag=1.
- NUM_CH=1 -> one entry write to 0x4580_0000, flag write next cycle, done one cycle after that.
